// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: grants one operation at a time, sequences IDLE -> EXEC -> RESP.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic [2:0]           req0_ctrl,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    input  logic [2:0]           req1_ctrl,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_data,
    output logic                 resp_id,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] a_q, b_q;
    logic [2:0]           ctrl_q;
    logic                 id_q;
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] resp_data_q, resp_data_d;
    logic                 resp_id_q, resp_id_d;
    logic                 pick0, pick1, hs;
    logic [2:0]           sel_ctrl;

`ifdef ALU_ARBITER_RR_EN
    logic last_q;

    // On contention, grant whoever did not win the previous handshake.
    assign pick0 = req0_valid && (!req1_valid || last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= req1_ready;
        end
    end
`else
    assign pick0 = req0_valid;
`endif

    assign pick1      = req1_valid && !pick0;
    assign req0_ready = (state_q == ST_IDLE) && pick0;
    assign req1_ready = (state_q == ST_IDLE) && pick1;
    assign hs         = req0_ready || req1_ready;
    assign sel_ctrl   = req1_ready ? req1_ctrl : req0_ctrl;

    // NOTE: operand registers carry no reset; they are only read after a handshake has loaded them.
    always_ff @(posedge clk) begin
        if (hs) begin
            a_q    <= req1_ready ? req1_a : req0_a;
            b_q    <= req1_ready ? req1_b : req0_b;
            ctrl_q <= sel_ctrl;
            id_q   <= req1_ready;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        result = '0;
        case (ctrl_q)
            OP_ADD:  result = a_q + b_q;
            OP_SUB:  result = a_q - b_q;
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            OP_MUL:  result = a_q * b_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_EXEC;
                    cnt_d   = (sel_ctrl == OP_MUL) ? MUL_CNT : 4'd1;
                end
            end
            ST_EXEC: begin
                if (cnt_q <= 4'd1) begin
                    state_d     = ST_RESP;
                    cnt_d       = 4'd0;
                    resp_data_d = result;
                    resp_id_d   = id_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver pushes expected responses, a monitor pops and compares.
// Grant-order expectations follow ALU_ARBITER_RR_EN the same way the design does.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int MC = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef struct {
        logic [W-1:0] data;
        logic         id;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_ctrl, req1_ctrl;
    logic         resp_valid, resp_ready, resp_id, busy;
    logic [W-1:0] resp_data;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_in_resp = 1'b0;
    exp_t mon_e;

    alu_arbiter #(.WORD_SIZE(W), .MUL_CYCLES(MC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every RESP cycle against the scoreboard head, pops on the response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_in_resp = 1'b0;
                continue;
            end
            if (busy) begin
                check("no_grant_while_busy", !(req0_ready || req1_ready), {req0_ready, req1_ready}, 0);
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 1'b0, resp_data, 0);
                end else begin
                    mon_e = sb_q[0];
                    check("resp_data", resp_data === mon_e.data, resp_data, mon_e.data);
                    check("resp_id", resp_id === mon_e.id, resp_id, mon_e.id);
                    if (!mon_in_resp) begin
                        check("resp_latency", cyc == mon_e.cyc, cyc, mon_e.cyc);
                    end
                    mon_in_resp = 1'b1;
                    if (resp_ready) begin
                        void'(sb_q.pop_front());
                        mon_in_resp = 1'b0;
                    end
                end
            end
        end
    end

    // Presents one request, waits for its grant, records the expectation, then scrambles operands.
    task automatic issue(input int rq, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_data);
        int lat;
        bit got;
        lat = (op == OP_MUL) ? 1 + MC : 2;
        got = 1'b0;
        if (rq == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = op;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (rq == 0) ? req0_ready : req1_ready;
        end
        check("grant_seen", got, got, 1);
        if (got) sb_q.push_back('{exp_data, (rq == 1), cyc + lat});
        @(posedge clk);
        #1;
        if (rq == 0) begin
            req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; req0_ctrl = OP_AND;
        end else begin
            req1_valid = 1'b0; req1_a = ~a; req1_b = ~b; req1_ctrl = OP_AND;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size() == 0, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g[4];
        bit   got, gid;
        int   k0, k1;

`ifdef ALU_ARBITER_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = OP_ADD;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = OP_ADD;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid === 1'b0, resp_valid, 0);
        check("rst_busy", busy === 1'b0, busy, 0);
        check("rst_resp_data", resp_data === '0, resp_data, 0);
        check("rst_resp_id", resp_id === 1'b0, resp_id, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Both requesters valid throughout: grant order depends on the arbitration mode.
        k0 = 1; k1 = 1;
        req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_a = k0;    req0_b = 100;
        req1_valid = 1'b1; req1_ctrl = OP_SUB; req1_a = 1000;  req1_b = k1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            gid = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = req0_ready || req1_ready;
                gid = req1_ready;
            end
            check("arb_grant", got && (gid == exp_g[g]), {got, gid}, {1'b1, exp_g[g]});
            if (got) begin
                if (gid) sb_q.push_back('{32'(1000 - k1), 1'b1, cyc + 2});
                else     sb_q.push_back('{32'(k0 + 100), 1'b0, cyc + 2});
            end
            @(posedge clk);
            #1;
            if (gid) begin k1++; req1_b = k1; end
            else     begin k0++; req0_a = k0; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        issue(0, OP_ADD, 32'd1, 32'd1, 32'd2);
        drain();

        // Mul: busy across EXEC and RESP, response at T+1+MUL_CYCLES.
        issue(1, OP_MUL, 32'd7, 32'd6, 32'd42);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_busy", busy === 1'b1, busy, 1);
        end
        @(negedge clk);
        check("mul_idle_after", busy === 1'b0, busy, 0);
        @(posedge clk);
        #1;

        issue(0, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        issue(1, 3'b111, 32'd5, 32'd3, 32'd0);
        issue(0, 3'b101, 32'd9, 32'd9, 32'd0);
        issue(0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        issue(1, OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
        issue(0, OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
        drain();

        // Backpressure: result held for 5 cycles while a new request waits ungranted.
        resp_ready = 1'b0;
        issue(0, OP_OR, 32'h4000_0000, 32'h0000_0001, 32'h4000_0001);
        req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_a = 32'd3; req0_b = 32'd4;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        check("bp_resp_seen", got, got, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid_held", resp_valid === 1'b1, resp_valid, 1);
            check("bp_no_grant", req0_ready === 1'b0, req0_ready, 0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        issue(0, OP_ADD, 32'd3, 32'd4, 32'd7);
        drain();

        // Reset during Mul EXEC drops the operation without a response.
        issue(1, OP_MUL, 32'd9, 32'd9, 32'd81);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        sb_q.delete();
        check("midrst_resp_valid", resp_valid === 1'b0, resp_valid, 0);
        check("midrst_busy", busy === 1'b0, busy, 0);
        check("midrst_resp_data", resp_data === '0, resp_data, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        issue(0, OP_ADD, 32'd20, 32'd22, 32'd42);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
